// File: rtl/sum_stream_accumulator_pkg.sv
// Shared sizing helpers for the sum stream accumulator and its neighbours.
package sum_stream_accumulator_pkg;

  // Result width large enough to hold count * (2^width - 1) without wrapping.
  function automatic int acc_width_f(input int width, input int count);
    return (count > 1) ? width + $clog2(count) : width;
  endfunction

endpackage

// File: rtl/sum_stream_accumulator.sv
// Accumulates each group of `count` consecutive sums from the adder stage
// into one wider result, presented on a valid/ready output stream.
module sum_stream_accumulator
  import sum_stream_accumulator_pkg::*;
#(
  parameter int width     = 4,
  parameter int count     = 4,
  parameter int acc_width = acc_width_f(width, count)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sum_valid,
  output logic                 sum_ready,
  input  logic [width-1:0]     sum_data,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [acc_width-1:0] acc_data
);

  localparam int cnt_w = (count > 1) ? $clog2(count) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(count - 1);

  logic [acc_width-1:0] acc_r;
  logic [cnt_w-1:0]     cnt;
  logic                 last;
  logic                 in_xfer;
  logic                 out_xfer;
  logic [acc_width-1:0] sum_ext;
  logic [acc_width-1:0] acc_next;

  // Handshake decode: only the group-completing sum waits on the output register.
  always_comb begin
    last      = (cnt == cnt_last);
    sum_ready = ~rst & (~last | ~acc_valid | acc_ready);
    in_xfer   = sum_valid & sum_ready;
    out_xfer  = acc_valid & acc_ready;
    sum_ext   = acc_width'(sum_data);
    acc_next  = acc_r + sum_ext;
  end

  // Partial-sum accumulation, group completion and output register with hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= '0;
      cnt       <= '0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
    end else begin
      if (out_xfer) begin
        acc_valid <= 1'b0;
      end
      // A completing group overrides the drain-clear above in the same cycle.
      if (in_xfer) begin
        if (last) begin
          acc_data  <= acc_next;
          acc_valid <= 1'b1;
          acc_r     <= '0;
          cnt       <= '0;
        end else begin
          acc_r <= acc_next;
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_stream_accumulator.sv
// Testbench for sum_stream_accumulator: directed table (count=4), streaming,
// count=1 directed sequence and randomized traffic against a queue model.
module tb_sum_stream_accumulator;
  import sum_stream_accumulator_pkg::*;

  localparam int W   = 4;
  localparam int AW4 = acc_width_f(W, 4);
  localparam int AW1 = acc_width_f(W, 1);

  logic clk;

  logic           c4_rst, c4_sv, c4_sr, c4_av, c4_ar;
  logic [W-1:0]   c4_sd;
  logic [AW4-1:0] c4_ad;

  logic           c1_rst, c1_sv, c1_sr, c1_av, c1_ar;
  logic [W-1:0]   c1_sd;
  logic [AW1-1:0] c1_ad;

  int checks = 0;
  int errors = 0;

  sum_stream_accumulator #(.width(W), .count(4)) dut4 (
    .clk(clk), .rst(c4_rst),
    .sum_valid(c4_sv), .sum_ready(c4_sr), .sum_data(c4_sd),
    .acc_valid(c4_av), .acc_ready(c4_ar), .acc_data(c4_ad)
  );

  sum_stream_accumulator #(.width(W), .count(1)) dut1 (
    .clk(clk), .rst(c1_rst),
    .sum_valid(c1_sv), .sum_ready(c1_sr), .sum_data(c1_sd),
    .acc_valid(c1_av), .acc_ready(c1_ar), .acc_data(c1_ad)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       sv;
    logic [3:0] sd;
    logic       ar;
    logic       exp_sr;
    logic       exp_av;
    logic [5:0] exp_ad;
    logic       chk_ad;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic sv, input logic [3:0] sd,
                              input logic ar, input logic esr, input logic eav,
                              input logic [5:0] ead, input logic cad);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sd = sd; v.ar = ar;
    v.exp_sr = esr; v.exp_av = eav; v.exp_ad = ead; v.chk_ad = cad;
    return v;
  endfunction

  // Each row: inputs driven this cycle, outputs expected before the next edge.
  task automatic fill_table();
    // reset state
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 6'h00, 1));
    // basic group 1,2,3,4
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 6'h0a, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    // max value
    for (int unsigned i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 4'hf, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 6'h3c, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    // backpressure
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 0, 1, 1, 6'h0a, 1));
    vecs.push_back(mk(0, 1, 6, 0, 1, 1, 6'h0a, 1));
    vecs.push_back(mk(0, 1, 7, 0, 1, 1, 6'h0a, 1));
    vecs.push_back(mk(0, 1, 8, 0, 0, 1, 6'h0a, 1));
    vecs.push_back(mk(0, 1, 8, 0, 0, 1, 6'h0a, 1));
    vecs.push_back(mk(0, 1, 8, 1, 1, 1, 6'h0a, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 6'h1a, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 6'h1a, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    // reset mid-group
    vecs.push_back(mk(0, 1, 5, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 6, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 9, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 6'h00, 1));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 6'h04, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    // reset with result pending
    for (int unsigned i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 6'h04, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 6'h04, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 6'h00, 1));
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      @(negedge clk);
      c4_rst = vecs[i].rst; c4_sv = vecs[i].sv; c4_sd = vecs[i].sd; c4_ar = vecs[i].ar;
      #1;
      chk($sformatf("tbl%0d_sum_ready", i), int'(c4_sr), int'(vecs[i].exp_sr));
      chk($sformatf("tbl%0d_acc_valid", i), int'(c4_av), int'(vecs[i].exp_av));
      if (vecs[i].chk_ad) chk($sformatf("tbl%0d_acc_data", i), int'(c4_ad), int'(vecs[i].exp_ad));
    end
    @(negedge clk);
    c4_rst = 0; c4_sv = 0; c4_ar = 1;
  endtask

  // 16 back-to-back sums; results must appear every 4 cycles with no stall.
  task automatic run_stream();
    int sums[16];
    int grp[4];
    for (int i = 0; i < 4; i++) grp[i] = 0;
    for (int i = 0; i < 16; i++) begin
      sums[i] = int'($urandom_range(0, 15));
      grp[i / 4] += sums[i];
    end
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      c4_sv = (k < 16);
      c4_sd = (k < 16) ? W'(sums[k]) : '0;
      c4_ar = 1'b1;
      #1;
      chk($sformatf("stream%0d_sum_ready", k), int'(c4_sr), 1);
      chk($sformatf("stream%0d_acc_valid", k), int'(c4_av), int'(k >= 4 && k % 4 == 0));
      if (k >= 4 && k % 4 == 0)
        chk($sformatf("stream%0d_acc_data", k), int'(c4_ad), grp[k / 4 - 1]);
    end
    @(negedge clk);
    c4_sv = 0;
  endtask

  task automatic run_c1_directed();
    @(negedge clk);
    c1_sv = 1; c1_sd = 4'h7; c1_ar = 1; #1;
    chk("c1_first_ready", int'(c1_sr), 1);
    chk("c1_reset_valid", int'(c1_av), 0);
    chk("c1_reset_data", int'(c1_ad), 0);
    @(negedge clk);
    c1_sv = 1; c1_sd = 4'h9; #1;
    chk("c1_res0_valid", int'(c1_av), 1);
    chk("c1_res0_data", int'(c1_ad), 7);
    chk("c1_second_ready", int'(c1_sr), 1);
    @(negedge clk);
    c1_sv = 0; #1;
    chk("c1_res1_valid", int'(c1_av), 1);
    chk("c1_res1_data", int'(c1_ad), 9);
    @(negedge clk);
    #1;
    chk("c1_drained", int'(c1_av), 0);
  endtask

  // Random valid/ready; the model keeps a list of pending inputs and of
  // completed results awaiting the consumer.
  task automatic run_random(input bit sel, input int c);
    int grp[$];
    int expq[$];
    int groups = 0;
    int cyc = 0;
    int s;
    bit sv, ar, exp_av, exp_sr;
    logic [W-1:0] d;
    int act_sr, act_av, act_ad;
    string tag;
    tag = sel ? "c1" : "c4";
    while ((groups < 100 || expq.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      sv = (groups < 100) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ar = ($urandom_range(0, 2) != 0);
      d  = W'($urandom);
      if (sel) begin c1_sv = sv; c1_ar = ar; c1_sd = d; end
      else     begin c4_sv = sv; c4_ar = ar; c4_sd = d; end
      #1;
      act_sr = sel ? int'(c1_sr) : int'(c4_sr);
      act_av = sel ? int'(c1_av) : int'(c4_av);
      act_ad = sel ? int'(c1_ad) : int'(c4_ad);
      exp_av = (expq.size() > 0);
      exp_sr = !(grp.size() == c - 1 && exp_av && !ar);
      chk($sformatf("%s_rand%0d_sum_ready", tag, cyc), act_sr, int'(exp_sr));
      chk($sformatf("%s_rand%0d_acc_valid", tag, cyc), act_av, int'(exp_av));
      if (exp_av && act_av != 0)
        chk($sformatf("%s_rand%0d_acc_data", tag, cyc), act_ad, expq[0]);
      if (exp_av && ar) void'(expq.pop_front());
      if (sv && exp_sr) begin
        grp.push_back(int'(d));
        if (grp.size() == c) begin
          s = 0;
          foreach (grp[i]) s += grp[i];
          expq.push_back(s);
          grp.delete();
          groups++;
        end
      end
      cyc++;
    end
    chk({tag, "_rand_timeout"}, int'(cyc < 5000), 1);
    chk({tag, "_rand_leftover"}, expq.size() + grp.size(), 0);
    @(negedge clk);
    if (sel) c1_sv = 0; else c4_sv = 0;
  endtask

  initial begin
    c4_rst = 1; c4_sv = 0; c4_sd = '0; c4_ar = 1;
    c1_rst = 1; c1_sv = 0; c1_sd = '0; c1_ar = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("c4_sum_ready_in_reset", int'(c4_sr), 0);
    chk("c1_sum_ready_in_reset", int'(c1_sr), 0);
    @(negedge clk);
    c4_rst = 0; c1_rst = 0;

    fill_table();
    run_table();
    run_stream();
    run_c1_directed();
    run_random(1'b0, 4);
    run_random(1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
